// File: rtl/vga_timing_gen_if.sv
// ============================================================================
//  Module   : vga_timing_gen_if
//  Brief    : Timing bundle from vga_timing_gen to the pixel mappers / pins.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_timing_gen_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       frame_end;

    modport master (
        output DrawX, DrawY, hs, vs, blank, frame_end
    );

    modport slave (
        input DrawX, DrawY, hs, vs, blank, frame_end
    );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
//  Module   : vga_timing_gen
//  Brief    : Free-running VGA H/V counters with registered syncs, blank and
//             frame-end strobe. Optional VGA_SYNC_DELAY_EN adds a 2-stage
//             delay on hs/vs/blank to line up with the mapper pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  wire logic            vga_clk,
    input  wire logic            reset,
    vga_timing_gen_if.master     vga
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // 11-bit compare constants so a 1024-wide sync end does not alias to 0
    localparam logic [10:0] c_H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] c_H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] c_HS_START   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] c_HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] c_V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] c_V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] c_VS_START   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] c_VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_size_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic [9:0] r_hc;
    logic [9:0] r_vc;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank;
    logic       r_frame_end;

    logic        w_h_last;
    logic        w_v_last;
    logic [9:0]  w_hc_next;
    logic [9:0]  w_vc_next;
    logic [10:0] w_hn;
    logic [10:0] w_vn;
    logic        w_hs_next;
    logic        w_vs_next;
    logic        w_blank_next;
    logic        w_frame_end_next;

    // Outputs are decoded from the next counter values so that, once
    // registered, they line up with DrawX/DrawY on the same cycle.
    always_comb begin
        w_h_last  = ({1'b0, r_hc} == c_H_LAST);
        w_v_last  = ({1'b0, r_vc} == c_V_LAST);
        w_hc_next = w_h_last ? 10'd0 : r_hc + 10'd1;
        w_vc_next = r_vc;
        if (w_h_last) begin
            w_vc_next = w_v_last ? 10'd0 : r_vc + 10'd1;
        end
        w_hn             = {1'b0, w_hc_next};
        w_vn             = {1'b0, w_vc_next};
        w_blank_next     = (w_hn < c_H_VIS) && (w_vn < c_V_VIS);
        w_hs_next        = !((w_hn >= c_HS_START) && (w_hn < c_HS_END));
        w_vs_next        = !((w_vn >= c_VS_START) && (w_vn < c_VS_END));
        w_frame_end_next = (w_hn == c_H_LAST) && (w_vn == c_V_LAST);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hc        <= 10'd0;
            r_vc        <= 10'd0;
            r_hs        <= 1'b1;
            r_vs        <= 1'b1;
            r_blank     <= 1'b1;
            r_frame_end <= 1'b0;
        end else begin
            r_hc        <= w_hc_next;
            r_vc        <= w_vc_next;
            r_hs        <= w_hs_next;
            r_vs        <= w_vs_next;
            r_blank     <= w_blank_next;
            r_frame_end <= w_frame_end_next;
        end
    end

    assign vga.DrawX     = r_hc;
    assign vga.DrawY     = r_vc;
    assign vga.frame_end = r_frame_end;

`ifdef VGA_SYNC_DELAY_EN
    logic [1:0] r_hs_dly;
    logic [1:0] r_vs_dly;
    logic [1:0] r_blank_dly;

    // Blank resets low here so nothing is drawn before the mapper pipe fills.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hs_dly    <= 2'b11;
            r_vs_dly    <= 2'b11;
            r_blank_dly <= 2'b00;
        end else begin
            r_hs_dly    <= {r_hs_dly[0], r_hs};
            r_vs_dly    <= {r_vs_dly[0], r_vs};
            r_blank_dly <= {r_blank_dly[0], r_blank};
        end
    end

    assign vga.hs    = r_hs_dly[1];
    assign vga.vs    = r_vs_dly[1];
    assign vga.blank = r_blank_dly[1];
`else
    assign vga.hs    = r_hs;
    assign vga.vs    = r_vs;
    assign vga.blank = r_blank;
`endif

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-clock timing generator driving every pixel mapper in the display path. Free-running horizontal and vertical counters produce `DrawX`/`DrawY`, active-low `hs`/`vs` syncs, the active-video qualifier `blank`, and a frame-end strobe. Mappers consume `DrawX`/`DrawY`/`blank` and return colour, so this block sits upstream of them. The syncs go straight to the VGA pins.

## Interface
Parameters:
- `H_VISIBLE`, 640: active pixels per line
- `H_FRONT`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync width, in pixels
- `H_BACK`, 48: horizontal back porch; `H_TOTAL` = sum of the four = 800
- `V_VISIBLE`, 480: active lines
- `V_FRONT`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync width, in lines
- `V_BACK`, 33: vertical back porch; `V_TOTAL` = sum of the four = 525

Ports:
- `vga_clk`  in  1  pixel clock (25.175 MHz nominal); the only clock
- `reset`  in  1  synchronous, active-high reset
- `DrawX`  out  10  horizontal counter `hc`, range 0..H_TOTAL-1
- `DrawY`  out  10  vertical counter `vc`, range 0..V_TOTAL-1
- `hs`  out  1  horizontal sync, active low
- `vs`  out  1  vertical sync, active low
- `blank`  out  1  1 = visible region (pixel must be drawn); 0 = porch or sync
- `frame_end`  out  1  one-cycle pulse on the last pixel of the frame

## Operation
- `hc` increments every `vga_clk` cycle. At H_TOTAL-1 it wraps to 0.
- `vc` increments only when `hc` wraps. When `hc` wraps with `vc` = V_TOTAL-1, `vc` wraps to 0.
- `DrawX` = `hc` and `DrawY` = `vc`, both registered. They are not clamped: they run through the porch and sync regions.
- `blank` = 1 iff `hc` < H_VISIBLE and `vc` < V_VISIBLE.
- `hs` = 0 iff H_VISIBLE+H_FRONT ≤ `hc` < H_VISIBLE+H_FRONT+H_SYNC. With defaults, that is 656..751.
- `vs` = 0 iff V_VISIBLE+V_FRONT ≤ `vc` < V_VISIBLE+V_FRONT+V_SYNC. With defaults, that is 490..491. `vs` switches on the same edge on which `hc` wraps.
- `frame_end` = 1 iff `hc` = H_TOTAL-1 and `vc` = V_TOTAL-1.
- `hs`, `vs`, `blank` and `frame_end` are registered, and are decoded from the next-state counter values. They are therefore cycle-aligned with `DrawX`/`DrawY`. There are no combinational paths from the counters to the outputs.
- Counter widths are 10 bits. Parameters must keep H_TOTAL and V_TOTAL ≤ 1024; this is checked by an elaboration-time assertion.

## Timing
- Reset values:
  - `hc`/`DrawX` = 0, `vc`/`DrawY` = 0
  - `hs` = 1, `vs` = 1, `frame_end` = 0
  - `blank` = 1, because (0,0) is visible
- Reset applied mid-frame: on the next edge, all outputs take their reset values and the frame restarts at (0,0). No partial sync pulse is extended.
- First edge after `reset` deasserts: `hc` = 1 and `vc` = 0.
- Line period is H_TOTAL cycles; frame period is H_TOTAL×V_TOTAL cycles (420 000 with defaults).
- `frame_end` is high for exactly one cycle per frame. It occurs in the cycle before (0,0), and does not occur during reset.
- Simultaneous horizontal and vertical wrap (`hc` = 799, `vc` = 524): on the next edge both counters go to 0, `blank` rises and `vs` stays high.

## Configuration
- `VGA_SYNC_DELAY_EN` defined:
  - `hs`, `vs` and `blank` pass through a 2-stage shift register clocked on `vga_clk`.
  - This matches the 2-cycle mapper pipeline (ROM read, then registered colour), so colour and syncs arrive at the pins together.
  - `DrawX`, `DrawY` and `frame_end` are not delayed.
  - Delay stages reset to `hs` = 1, `vs` = 1, `blank` = 0. Consequently `blank` is 0 for the first 2 cycles after reset.
- `VGA_SYNC_DELAY_EN` undefined: no delay stages; behaviour is exactly as given in Operation and Timing.

## Test plan
- Reset for 3 cycles, then release → `DrawX`=0, `DrawY`=0, `hs`=1, `vs`=1, `blank`=1 during reset; `DrawX`=1 on the first edge after release.
- Run one line → `blank` falls when `DrawX`=640; `hs`=0 exactly for `DrawX` 656..751 (96 cycles); `DrawY` increments when `DrawX` goes 799→0.
- Run one full frame → `vs`=0 for exactly 1600 cycles (lines 490–491); `blank`=1 for exactly 307 200 cycles; `frame_end` pulses once, at (799,524).
- Assert `reset` at `DrawX`=700, `DrawY`=491 (inside both syncs) → the next edge gives `hs`=1, `vs`=1, `DrawX`=0, `DrawY`=0, `blank`=1.
- Check frame-to-frame spacing → consecutive `frame_end` pulses are exactly 420 000 cycles apart across 3 frames.
- With `VGA_SYNC_DELAY_EN` defined → `hs` falls 2 cycles after `DrawX`=656; `blank` falls 2 cycles after `DrawX`=640; `DrawX` timing is unchanged.
